alu8_cmd_ctrl: RTL and testbench

ALU8_CMD_CTRL -- requirements
Module: alu8_cmd_ctrl

---
 rtl/alu8_cmd_ctrl.sv | 139 +++++++++++++
 tb/tb_alu8_cmd_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_cmd_ctrl.sv
// Command queue and sequencer for an external combinational 8-bit ALU.
// Commands are queued, issued one at a time, and each captured result is held until downstream takes it.
module alu8_cmd_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic [31:0] alu_cmd,
    input  logic [7:0]  alu_res,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        res_err,
    input  logic        res_ready,
    output logic        busy,
    output logic [15:0] cmd_count,
    output logic [1:0]  dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, empty, push, pop;
    logic [31:0]   head;

    state_t        state_q, state_d;
    logic [31:0]   alu_cmd_q, alu_cmd_d;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q, res_data_d;
    logic          res_err_q, res_err_d;
    logic [7:0]    last_result_q, last_result_d;
    logic [15:0]   cmd_count_q, cmd_count_d;

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = fifo_mem[rd_ptr_q];
    assign push  = cmd_valid && !full && !rst;
    assign pop   = (state_q == S_IDLE) && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d       = state_q;
        alu_cmd_d     = alu_cmd_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_err_d     = res_err_q;
        last_result_d = last_result_q;
        cmd_count_d   = cmd_count_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    alu_cmd_d = head;
                    if (head[27]) begin
                        alu_cmd_d[15:8] = last_result_q;
                    end
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_data_d    = alu_res;
                last_result_d = alu_res;
                res_valid_d   = 1'b1;
                res_err_d     = (alu_cmd_q[31:28] == 4'd3) && (alu_cmd_q[7:0] == 8'h00);
                state_d       = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_count_d = cmd_count_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            alu_cmd_q     <= 32'h0;
            res_valid_q   <= 1'b0;
            res_data_q    <= 8'h00;
            res_err_q     <= 1'b0;
            last_result_q <= 8'h00;
            cmd_count_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            alu_cmd_q     <= alu_cmd_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_err_q     <= res_err_d;
            last_result_q <= last_result_d;
            cmd_count_q   <= cmd_count_d;
        end
    end

    // Ready stays high during reset so upstream never sees a stale full flag.
    assign cmd_ready = rst || !full;
    assign alu_cmd   = alu_cmd_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign cmd_count = cmd_count_q;
    assign busy      = !empty || (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu8_cmd_ctrl.sv
// Directed bench for alu8_cmd_ctrl with a small behavioural ALU model driving alu_res.
module tb_alu8_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic [31:0] alu_cmd;
  logic [7:0]  alu_res;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_err;
  logic        res_ready;
  logic        busy;
  logic [15:0] cmd_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  alu8_cmd_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .alu_cmd(alu_cmd), .alu_res(alu_res),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .res_ready(res_ready), .busy(busy), .cmd_count(cmd_count),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ALU model: 0 add, 1 sub, 2 mul, 3 div (divide by zero gives FF), other xor
  logic [7:0] alu_a, alu_b;
  always_comb begin
    alu_a = alu_cmd[15:8];
    alu_b = alu_cmd[7:0];
    case (alu_cmd[31:28])
      4'd0:    alu_res = alu_a + alu_b;
      4'd1:    alu_res = alu_a - alu_b;
      4'd2:    alu_res = alu_a * alu_b;
      4'd3:    alu_res = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
      default: alu_res = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    check("push_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // waits for a result, checks it, then consumes it (res_ready assumed high)
  task automatic wait_result(input string tag, input logic [7:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, 32'(res_data), 32'(exp_d));
    check({tag, "_err"}, 32'(res_err), 32'(exp_e));
    tick();
  endtask

  initial begin
    int accepted;
    int n;
    logic go;

    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 32'h0; res_ready = 1'b0;
    repeat (2) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu_cmd", alu_cmd, 32'h0);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    rst = 1'b0;

    // ADD with exact latency
    res_ready = 1'b1;
    push_one(32'h0000_0503);
    check("add_busy", 32'(busy), 32'd1);
    check("add_valid_e0", 32'(res_valid), 32'd0);
    tick();
    check("add_alu_cmd", alu_cmd, 32'h0000_0503);
    check("add_valid_e1", 32'(res_valid), 32'd0);
    tick();
    check("add_valid_e2", 32'(res_valid), 32'd1);
    check("add_data", 32'(res_data), 32'h08);
    check("add_err", 32'(res_err), 32'd0);
    tick();
    check("add_valid_cleared", 32'(res_valid), 32'd0);
    check("add_count", 32'(cmd_count), 32'd1);
    check("add_busy_idle", 32'(busy), 32'd0);

    // chain: second command takes A from the previous result
    cmd_valid = 1'b1; cmd_data = 32'h2000_0304;
    tick();
    cmd_data = 32'h3800_0003;
    tick();
    cmd_valid = 1'b0;
    check("chain_alu_cmd0", alu_cmd, 32'h2000_0304);
    wait_result("chain0", 8'h0C, 1'b0);
    tick();
    check("chain_alu_cmd1", alu_cmd, 32'h3800_0C03);
    wait_result("chain1", 8'h04, 1'b0);

    // divide by zero, then a clean command
    push_one(32'h3000_0700);
    wait_result("div0", 8'hFF, 1'b1);
    push_one(32'h0000_0101);
    wait_result("add11", 8'h02, 1'b0);
    check("count_after_div", 32'(cmd_count), 32'd5);

    // backpressure: queue fills while the FSM waits in DONE
    res_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      cmd_valid = 1'b1;
      cmd_data  = {16'h0, 8'(accepted + 1), 8'h10};
      go = cmd_ready;
      tick();
      if (go) begin
        exp_q.push_back(8'(accepted + 1 + 16));
        accepted++;
      end
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 32'd5);
    check("bp_ready_low", 32'(cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      res_ready = ~res_ready;
      if (res_valid && res_ready) begin
        check("bp_busy_before", 32'(busy), 32'd1);
        check("bp_data", 32'(res_data), 32'(exp_q.pop_front()));
      end
      tick();
      n++;
    end
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_busy_after", 32'(busy), 32'd0);
    check("bp_count", 32'(cmd_count), 32'd10);
    res_ready = 1'b1;

    // reset while a command is executing with more queued
    cmd_valid = 1'b1;
    cmd_data = 32'h0000_2020; tick();
    cmd_data = 32'h0000_3030; tick();
    cmd_data = 32'h0000_4040; tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_in_exec", 32'(dbg_state), 32'd1);
    rst = 1'b1; cmd_valid = 1'b1; cmd_data = 32'h0000_5050;
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    tick();
    check("mid_state", 32'(dbg_state), 32'd0);
    check("mid_alu_cmd", alu_cmd, 32'h0);
    check("mid_res_valid", 32'(res_valid), 32'd0);
    check("mid_res_data", 32'(res_data), 32'h0);
    check("mid_res_err", 32'(res_err), 32'd0);
    check("mid_count", 32'(cmd_count), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ready", 32'(cmd_ready), 32'd1);
    tick();
    check("mid_no_push", 32'(busy), 32'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_no_stale", 32'({res_valid, busy}), 32'd0);
    end

    // last_result must have been cleared: chained A becomes 0
    push_one(32'h0800_0005);
    tick();
    check("post_rst_chain_cmd", alu_cmd, 32'h0800_0005);
    wait_result("post_rst_chain", 8'h05, 1'b0);
    check("post_rst_count", 32'(cmd_count), 32'd1);

    // counter wrap, preloaded near the top
    @(negedge clk);
    force dut.cmd_count_q = 16'hFFFE;
    #1;
    release dut.cmd_count_q;
    tick();
    check("wrap_preload", 32'(cmd_count), 32'h0000_FFFE);
    push_one(32'h0000_0101);
    wait_result("wrap0", 8'h02, 1'b0);
    check("wrap_ffff", 32'(cmd_count), 32'h0000_FFFF);
    push_one(32'h1000_0903);
    wait_result("wrap1", 8'h06, 1'b0);
    check("wrap_zero", 32'(cmd_count), 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
